// File: rtl/riscv_fetch_pc_pkg.sv
// rtl/riscv_fetch_pc_pkg.sv - shared fetch-stage constants, state encodings and helpers
package riscv_fetch_pc_pkg;

  localparam int          FETCH_XLEN     = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

  // Encodings are also decoded by trace/debug monitors; keep them stable.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/riscv_fetch_pc_if.sv
// rtl/riscv_fetch_pc_if.sv - instruction-memory req/gnt + rvalid port
interface riscv_fetch_pc_if
  import riscv_fetch_pc_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN
);

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/riscv_fetch_pc.sv
// rtl/riscv_fetch_pc.sv - RV32I program counter and single-outstanding instruction fetch
module riscv_fetch_pc
  import riscv_fetch_pc_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [XLEN-1:0]         i_pc_next,
  input  logic                    i_pc_redirect,
  output logic [XLEN-1:0]         o_pc_plus4,
  output logic                    o_misalign,
  riscv_fetch_pc_if.master        imem,
  output logic                    o_if_valid,
  output logic [XLEN-1:0]         o_if_pc,
  output logic [31:0]             o_if_instr,
  input  logic                    i_if_ready
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            kill_q;
  logic            misalign_q;
  logic            if_valid_q;
  logic [XLEN-1:0] if_pc_q;
  logic [31:0]     if_instr_q;

  logic            redirect_ok;
  logic            redirect_bad;
  logic [XLEN-1:0] pc_seq_d;

  assign redirect_ok  = i_pc_redirect &&  is_word_aligned(i_pc_next[1:0]);
  assign redirect_bad = i_pc_redirect && !is_word_aligned(i_pc_next[1:0]);
  assign pc_seq_d     = pc_q + PC_STEP;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
    end else begin
      misalign_q <= redirect_bad;
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_REQ;
          if (redirect_ok) pc_q <= i_pc_next;
        end
        ST_REQ: begin
          // Redirect before gnt replaces the pending request; after gnt the
          // response in flight belongs to the old path and must be killed.
          if (redirect_ok) pc_q <= i_pc_next;
          if (imem.gnt) begin
            state_q <= ST_WAIT;
            kill_q  <= redirect_ok;
          end
        end
        ST_WAIT: begin
          if (imem.rvalid) begin
            kill_q <= 1'b0;
            if (kill_q || redirect_ok) begin
              state_q <= ST_REQ;
            end else begin
              if_valid_q <= 1'b1;
              if_pc_q    <= pc_q;
              if_instr_q <= imem.rdata;
              state_q    <= ST_HOLD;
            end
            if (redirect_ok) pc_q <= i_pc_next;
          end else if (redirect_ok) begin
            pc_q   <= i_pc_next;
            kill_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_ok) begin
            pc_q       <= i_pc_next;
            if_valid_q <= 1'b0;
            state_q    <= ST_REQ;
          end else if (if_valid_q && i_if_ready) begin
            pc_q       <= pc_seq_d;
            if_valid_q <= 1'b0;
            state_q    <= ST_REQ;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign imem.req   = (state_q == ST_REQ);
  assign imem.addr  = pc_q;
  assign o_misalign = misalign_q;
  assign o_if_valid = if_valid_q;
  assign o_if_pc    = if_pc_q;
  assign o_if_instr = if_instr_q;
  assign o_pc_plus4 = if_pc_q + PC_STEP;

endmodule

// File: tb/tb_riscv_fetch_pc.sv
// tb/tb_riscv_fetch_pc.sv - randomized bench with a behavioural fetch model
module tb_riscv_fetch_pc;
  import riscv_fetch_pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_next = '0;
  logic        redirect = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;
  logic [31:0] pc_plus4, if_pc, if_instr;
  logic        misalign, if_valid;

  always #5 clk = ~clk;

  riscv_fetch_pc_if imem ();
  assign imem.gnt    = gnt;
  assign imem.rvalid = rvalid;
  assign imem.rdata  = rdata;

  riscv_fetch_pc dut (
    .i_clk(clk), .i_rst(rst), .i_pc_next(pc_next), .i_pc_redirect(redirect),
    .o_pc_plus4(pc_plus4), .o_misalign(misalign), .imem(imem),
    .o_if_valid(if_valid), .o_if_pc(if_pc), .o_if_instr(if_instr), .i_if_ready(ready)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: what has been fetched, what is owed, what is buffered.
  bit          m_init = 0, m_boot, m_busy, m_stale, m_buf, m_mis;
  logic [31:0] m_pc, m_bpc, m_binstr;

  // Memory environment
  bit          mem_pend = 0, force_en = 0, stray_req = 0, seen_dead = 0;
  int          mem_cnt = 0, lat = 1;
  logic [31:0] mem_addr, force_data;
  logic [31:0] gnt_log[$], dl_pc[$], dl_instr[$], dl_p4[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("imem_req",  {31'b0, imem.req}, {31'b0, !m_boot && !m_busy && !m_buf});
    chk("imem_addr", imem.addr, m_pc);
    chk("if_valid",  {31'b0, if_valid}, {31'b0, m_buf});
    chk("if_pc",     if_pc, m_bpc);
    chk("if_instr",  if_instr, m_binstr);
    chk("pc_plus4",  pc_plus4, m_bpc + 32'd4);
    chk("misalign",  {31'b0, misalign}, {31'b0, m_mis});
  endtask

  task automatic model_step();
    bit good;
    if (rst) begin
      m_init = 1; m_boot = 1; m_busy = 0; m_stale = 0; m_buf = 0; m_mis = 0;
      m_pc = FETCH_RESET_PC; m_bpc = FETCH_RESET_PC; m_binstr = NOP_INSTR;
      return;
    end
    good  = redirect && (pc_next[1:0] == 2'b00);
    m_mis = redirect && (pc_next[1:0] != 2'b00);
    if (m_boot) begin
      m_boot = 0;
      if (good) m_pc = pc_next;
    end else if (!m_busy && !m_buf) begin
      if (gnt) begin m_busy = 1; m_stale = good; end
      if (good) m_pc = pc_next;
    end else if (m_busy) begin
      if (rvalid) begin
        m_busy = 0;
        if (!(m_stale || good)) begin m_buf = 1; m_bpc = m_pc; m_binstr = rdata; end
        m_stale = 0;
        if (good) m_pc = pc_next;
      end else if (good) begin
        m_pc = pc_next; m_stale = 1;
      end
    end else begin
      if (good) begin m_pc = pc_next; m_buf = 0; end
      else if (ready) begin m_buf = 0; m_pc = m_pc + 32'd4; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (m_init) compare_all();
    if (if_valid && if_instr == 32'hDEAD_BEEF) seen_dead = 1;
    if (rvalid) mem_pend = 0;
    if (imem.req && gnt) begin
      mem_pend = 1; mem_addr = imem.addr; mem_cnt = lat;
      if (!rst) gnt_log.push_back(imem.addr);
    end
    if (!rst && if_valid && ready && !(redirect && pc_next[1:0] == 2'b00)) begin
      dl_pc.push_back(if_pc); dl_instr.push_back(if_instr); dl_p4.push_back(pc_plus4);
    end
    model_step();
    @(posedge clk); #1;
    rvalid = 0; redirect = 0;
    if (stray_req && !mem_pend && !m_busy) begin
      rvalid = 1; rdata = $urandom;
    end else if (mem_pend) begin
      if (mem_cnt <= 1) begin
        rvalid = 1;
        rdata  = force_en ? force_data : word_of(mem_addr);
        force_en = 0;
      end else begin
        mem_cnt--;
      end
    end
    stray_req = 0;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); dl_pc.delete(); dl_instr.delete(); dl_p4.delete();
  endtask

  task automatic wait_deliver(input int n, input string name);
    int k = 0;
    while (dl_pc.size() < n && k < 60) begin tick(); k++; end
    if (dl_pc.size() < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, dl_pc.size(), n);
    end
  endtask

  task automatic wait_grant(input string name);
    int k = 0;
    int s = gnt_log.size();
    while (gnt_log.size() == s && k < 30) begin tick(); k++; end
    if (gnt_log.size() == s) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=0 required=1", name);
    end
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!if_valid && k < 30) begin tick(); k++; end
    chk(name, {31'b0, if_valid}, 32'd1);
  endtask

  logic [31:0] snap_pc, snap_instr, snap_addr;

  initial begin
    // Reset and sequential fetch with single-cycle memory
    rst = 1; tick();
    chk("rst_req", {31'b0, imem.req}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    rst = 0; gnt = 1; ready = 1; lat = 1;
    clear_logs();
    wait_deliver(3, "seq");
    if (dl_pc.size() >= 3 && gnt_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("seq_addr", gnt_log[i], 32'(4 * i));
        chk("seq_if_pc", dl_pc[i], 32'(4 * i));
        chk("seq_instr", dl_instr[i], word_of(32'(4 * i)));
        chk("seq_plus4", dl_p4[i], 32'(4 * i + 4));
      end
    end

    // Decode stall: buffer must hold, no new request
    ready = 0;
    wait_valid("stall_fill");
    snap_instr = if_instr;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'b0, if_valid}, 32'd1);
      chk("stall_instr", if_instr, snap_instr);
      chk("stall_req", {31'b0, imem.req}, 32'd0);
    end

    // Withheld gnt, redirect replaces the pending request
    gnt = 0; ready = 1; tick();
    chk("hold_addr", imem.addr, 32'h10);
    chk("hold_req", {31'b0, imem.req}, 32'd1);
    tick();
    redirect = 1; pc_next = 32'h200; tick();
    chk("replace_addr", imem.addr, 32'h200);
    tick();
    chk("replace_addr2", imem.addr, 32'h200);
    gnt = 1; clear_logs();
    wait_deliver(1, "replace");
    if (dl_pc.size() >= 1) begin
      chk("replace_if_pc", dl_pc[0], 32'h200);
      chk("replace_instr", dl_instr[0], word_of(32'h200));
      chk("replace_gnt", gnt_log[0], 32'h200);
    end

    // Redirect while waiting: late response is killed
    clear_logs(); lat = 3; force_en = 1; force_data = 32'hDEAD_BEEF;
    wait_grant("kill_grant");
    lat = 1;
    redirect = 1; pc_next = 32'h400; tick();
    wait_deliver(1, "kill");
    if (dl_pc.size() >= 1 && gnt_log.size() >= 2) begin
      chk("kill_if_pc", dl_pc[0], 32'h400);
      chk("kill_instr", dl_instr[0], word_of(32'h400));
      chk("kill_gnt", gnt_log[1], 32'h400);
    end
    chk("kill_no_dead", {31'b0, seen_dead}, 32'd0);

    // Misaligned redirect is flagged for one cycle and otherwise ignored
    ready = 0;
    wait_valid("mis_fill");
    snap_pc = if_pc; snap_instr = if_instr; snap_addr = imem.addr;
    redirect = 1; pc_next = 32'h102; tick();
    chk("mis_pulse", {31'b0, misalign}, 32'd1);
    chk("mis_if_pc", if_pc, snap_pc);
    chk("mis_instr", if_instr, snap_instr);
    chk("mis_addr", imem.addr, snap_addr);
    chk("mis_valid", {31'b0, if_valid}, 32'd1);
    tick();
    chk("mis_clear", {31'b0, misalign}, 32'd0);
    chk("mis_addr2", imem.addr, snap_addr);

    // Reset while waiting; stray response afterwards ignored
    ready = 1; lat = 2; clear_logs();
    wait_grant("rst_grant");
    rst = 1; tick();
    chk("rst2_req", {31'b0, imem.req}, 32'd0);
    chk("rst2_if_valid", {31'b0, if_valid}, 32'd0);
    rst = 0; lat = 1; clear_logs();
    wait_deliver(1, "rst2");
    if (dl_pc.size() >= 1) begin
      chk("rst2_gnt", gnt_log[0], 32'h0);
      chk("rst2_if_pc", dl_pc[0], 32'h0);
      chk("rst2_instr", dl_instr[0], word_of(32'h0));
    end

    // Address wrap at the top of memory
    redirect = 1; pc_next = 32'hFFFF_FFFC; tick();
    clear_logs();
    wait_deliver(2, "wrap");
    if (dl_pc.size() >= 2 && gnt_log.size() >= 2) begin
      chk("wrap_if_pc", dl_pc[0], 32'hFFFF_FFFC);
      chk("wrap_plus4", dl_p4[0], 32'h0);
      chk("wrap_gnt", gnt_log[1], 32'h0);
      chk("wrap_if_pc2", dl_pc[1], 32'h0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      gnt   = 1'($urandom_range(0, 1));
      ready = ($urandom_range(0, 9) < 6);
      lat   = $urandom_range(1, 3);
      rst   = ($urandom_range(0, 199) == 0);
      stray_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) begin
        redirect = 1;
        case ($urandom_range(0, 3))
          0: pc_next = {$urandom} & 32'hFFFF_FFFC;
          1: pc_next = 32'hFFFF_FFF8 + 32'(4 * $urandom_range(0, 1));
          2: pc_next = ({$urandom} & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
          default: pc_next = 32'(4 * $urandom_range(0, 63));
        endcase
      end
      if (m_init && if_valid) chk("rand_data", if_instr, word_of(if_pc));
      tick();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
